// File: rtl/mem_access_sequencer_if.sv
// Request, memory-bus and completion signals of the memory access sequencer.
// slave = sequencer side, master = requester/memory side.
interface mem_access_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] rt_data;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic [31:0] load_data;
    logic        err;

    modport slave (
        input  req_valid, opcode, addr, rt_data, mem_rdata, mem_ack,
        output req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, done, load_data, err
    );

    modport master (
        output req_valid, opcode, addr, rt_data, mem_rdata, mem_ack,
        input  req_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, done, load_data, err
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sub-word load/store sequencer: read-merge-write over a word-wide memory bus.
// One access in flight; new requests accepted only in IDLE; bus phases abort after ACK_TIMEOUT cycles.
module mem_access_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mem_access_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SB = 6'b101000;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_MERGE, S_WRITE, S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [5:0]        r_opcode;
    logic [1:0]        r_lane;
    logic [31:0]       r_rt;
    logic [31:0]       r_rdata;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_load;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_in_legal;
    logic              w_in_sw;
    logic              w_timeout;
    logic              w_set_err;
    logic              w_is_store;
    logic [31:0]       w_load_merge;
    logic [31:0]       w_store_merge;

    assign w_accept   = bus.req_valid && (r_state == S_IDLE);
    assign w_in_sw    = (bus.opcode == OP_SW);
    assign w_timeout  = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
    // Every supported store opcode has bit 3 set and every load has it clear.
    assign w_is_store = r_opcode[3];

    always_comb begin
        w_in_legal = 1'b0;
        case (bus.opcode)
            OP_LW, OP_SW: w_in_legal = (bus.addr[1:0] == 2'b00);
            OP_LH, OP_SH: w_in_legal = ~bus.addr[0];
            OP_LB, OP_SB: w_in_legal = 1'b1;
            default:      w_in_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_load_merge  = r_rt;
        w_store_merge = r_rdata;
        case (r_opcode)
            OP_LW: w_load_merge = r_rdata;
            OP_LH: begin
                if (r_lane[1]) w_load_merge[31:16] = r_rdata[15:0];
                else           w_load_merge[15:0]  = r_rdata[15:0];
            end
            OP_LB: w_load_merge[{r_lane, 3'b000} +: 8] = r_rdata[7:0];
            OP_SH: begin
                if (r_lane[1]) w_store_merge[31:16] = r_rt[15:0];
                else           w_store_merge[15:0]  = r_rt[15:0];
            end
            OP_SB: w_store_merge[{r_lane, 3'b000} +: 8] = r_rt[7:0];
            default: ;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_in_legal) begin
                        w_next    = S_FINISH;
                        w_set_err = 1'b1;
                    end else if (w_in_sw) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (bus.mem_ack) begin
                    w_next = S_MERGE;
                end else if (w_timeout) begin
                    w_next    = S_FINISH;
                    w_set_err = 1'b1;
                end
            end
            S_MERGE:  w_next = w_is_store ? S_WRITE : S_FINISH;
            S_WRITE: begin
                if (bus.mem_ack) begin
                    w_next = S_FINISH;
                end else if (w_timeout) begin
                    w_next    = S_FINISH;
                    w_set_err = 1'b1;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_opcode   <= '0;
            r_lane     <= '0;
            r_rt       <= '0;
            r_rdata    <= '0;
            r_wdata    <= '0;
            r_mem_addr <= '0;
            r_load     <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            // Counter runs only inside a bus phase, so it is zero on every entry to READ/WRITE.
            r_cnt <= (r_state == S_READ || r_state == S_WRITE) ? r_cnt + CNT_W'(1) : '0;
            if (w_accept) begin
                r_opcode   <= bus.opcode;
                r_lane     <= bus.addr[1:0];
                r_rt       <= bus.rt_data;
                r_mem_addr <= {bus.addr[31:2], 2'b00};
                r_err      <= w_set_err;
                r_load     <= '0;
                if (w_in_sw) r_wdata <= bus.rt_data;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (r_state == S_READ && bus.mem_ack) r_rdata <= bus.mem_rdata;
            if (r_state == S_MERGE) begin
                if (w_is_store) r_wdata <= w_store_merge;
                else            r_load  <= w_load_merge;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.mem_rd_en = (r_state == S_READ);
    assign bus.mem_wr_en = (r_state == S_WRITE);
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.done      = (r_state == S_FINISH);
    assign bus.err       = (r_state == S_FINISH) && r_err;
    assign bus.load_data = (r_state == S_FINISH) ? r_load : 32'h0;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized scoreboard bench for mem_access_sequencer with a byte-lane reference model
// and a memory responder that inserts programmable ack delays.
module tb_mem_access_sequencer;
    localparam int TO = 15;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SB = 6'b101000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_access_sequencer_if bus ();

    mem_access_sequencer #(.ACK_TIMEOUT(TO)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          lat;
        int          rdc;
        int          wrc;
        int          acc;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } bus_t;

    exp_t        sb_q[$];
    bus_t        bus_q[$];
    logic [31:0] mem [16];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ad_r = 0;
    int          ad_w = 0;
    bit          ack_never = 1'b0;
    int          rdc = 0;
    int          wrc = 0;
    int          bw = 0;
    logic [31:0] first_wd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Loads replace the addressed lane of Rt with the low bytes of the memory word;
    // stores replace the addressed lane of the memory word with the low bytes of Rt.
    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] r,
                                  input logic [31:0] m, output logic e, output logic is_rd,
                                  output logic is_wr, output logic [31:0] ld, output logic [31:0] wd);
        int size;
        int base;
        logic store;
        logic [7:0] rb [4];
        logic [7:0] mb [4];
        logic [7:0] ob [4];
        size  = 0;
        store = 1'b0;
        case (op)
            OP_LW: size = 4;
            OP_LH: size = 2;
            OP_LB: size = 1;
            OP_SW: begin size = 4; store = 1'b1; end
            OP_SH: begin size = 2; store = 1'b1; end
            OP_SB: begin size = 1; store = 1'b1; end
            default: size = 0;
        endcase
        base = int'(a[1:0]);
        if (size == 0) e = 1'b1;
        else           e = (base % size) != 0;
        for (int i = 0; i < 4; i++) begin
            rb[i] = r[8*i +: 8];
            mb[i] = m[8*i +: 8];
        end
        ld    = '0;
        wd    = '0;
        is_rd = !e && !(store && size == 4);
        is_wr = !e && store;
        if (!e) begin
            for (int i = 0; i < 4; i++) ob[i] = store ? mb[i] : rb[i];
            for (int i = 0; i < size; i++) ob[base + i] = store ? rb[i] : mb[i];
            for (int i = 0; i < 4; i++) begin
                if (store) wd[8*i +: 8] = ob[i];
                else       ld[8*i +: 8] = ob[i];
            end
        end
    endfunction

    always @(posedge clk) cyc++;

    // Memory responder: acks after the programmed delay, random acks outside bus phases.
    always @(posedge clk) begin
        bus_t b;
        #1;
        if (rst) begin
            bus.mem_ack = 1'b0;
            bw = 0;
        end else if (bus.mem_rd_en || bus.mem_wr_en) begin
            if (!ack_never && bw >= (bus.mem_rd_en ? ad_r : ad_w)) begin
                bus.mem_ack = 1'b1;
                bw = 0;
                if (bus_q.size() == 0) begin
                    check("unexpected_bus_op", 32'(bus_q.size()), 32'd1);
                end else begin
                    b = bus_q.pop_front();
                    check("bus_is_write", 32'(bus.mem_wr_en), 32'(b.wr));
                    check("mem_addr", bus.mem_addr, b.a);
                    if (b.wr) check("mem_wdata", bus.mem_wdata, b.d);
                end
                if (bus.mem_wr_en) mem[bus.mem_addr[5:2]] = bus.mem_wdata;
                else               bus.mem_rdata = mem[bus.mem_addr[5:2]];
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                bw++;
            end
        end else begin
            bus.mem_ack   = ($urandom_range(0, 3) == 0);
            bus.mem_rdata = $urandom;
            bw = 0;
        end
    end

    // Monitor: strobe invariants every cycle, scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rdc = 0;
            wrc = 0;
        end else begin
            check("both_strobes", 32'(bus.mem_rd_en & bus.mem_wr_en), 32'd0);
            if (bus.mem_wr_en) begin
                if (wrc == 0) first_wd = bus.mem_wdata;
                else          check("wdata_stable", bus.mem_wdata, first_wd);
            end
            rdc += int'(bus.mem_rd_en);
            wrc += int'(bus.mem_wr_en);
            if (bus.done) begin
                check("ready_in_finish", 32'(bus.req_ready), 32'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("err", 32'(bus.err), 32'(e.err));
                    check("load_data", bus.load_data, e.ld);
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    check("rd_cycles", 32'(rdc), 32'(e.rdc));
                    check("wr_cycles", 32'(wrc), 32'(e.wrc));
                end
                rdc = 0;
                wrc = 0;
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_load_data", bus.load_data, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] r,
                         input int dr, input int dw);
        exp_t e;
        logic is_rd;
        logic is_wr;
        logic [31:0] wd;
        int n;
        model(op, a, r, mem[a[5:2]], e.err, is_rd, is_wr, e.ld, wd);
        ad_r = dr;
        ad_w = dw;
        if (ack_never && (is_rd || is_wr)) begin
            e.err = 1'b1;
            e.ld  = '0;
            e.lat = TO;
            e.rdc = is_rd ? TO : 0;
            e.wrc = is_rd ? 0 : TO;
        end else begin
            e.rdc = is_rd ? dr + 1 : 0;
            e.wrc = is_wr ? dw + 1 : 0;
            e.lat = e.err ? 0 : ((is_rd ? e.rdc + 1 : 0) + e.wrc);
            if (is_rd) bus_q.push_back('{wr: 1'b0, a: {a[31:2], 2'b00}, d: 32'h0});
            if (is_wr) bus_q.push_back('{wr: 1'b1, a: {a[31:2], 2'b00}, d: wd});
        end
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.opcode    = op;
        bus.addr      = a;
        bus.rt_data   = r;
        e.acc = cyc + 1;
        sb_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.opcode    = 6'($urandom);
        bus.addr      = $urandom;
        bus.rt_data   = $urandom;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("done_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        check("bus_ops_drained", 32'(bus_q.size()), 32'd0);
        bus_q.delete();
    endtask

    task automatic reset_during_read();
        int n;
        ad_r = 8;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.opcode    = OP_LW;
        bus.addr      = 32'h84;
        bus.rt_data   = $urandom;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.mem_rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_read", 32'(bus.mem_rd_en), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        check("no_strobe_in_reset", 32'(bus.mem_rd_en | bus.mem_wr_en), 32'd0);
        rst = 1'b0;
        bus_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  ops [7];
        logic [5:0]  op;
        logic [31:0] a;
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_LH; ops[3] = OP_SH;
        ops[4] = OP_LB; ops[5] = OP_SB; ops[6] = 6'b000000;
        bus.req_valid = 1'b0;
        bus.opcode    = '0;
        bus.addr      = '0;
        bus.rt_data   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        #1 rst = 1'b1;
        #1 check_reset_vals();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        mem[0] = 32'h00000011;
        issue(OP_LB, 32'h102, 32'hAABBCCDD, 0, 0);
        mem[0] = 32'h11223344;
        issue(OP_SB, 32'h203, 32'h000000EE, 0, 0);
        mem[4] = 32'h12345678;
        issue(OP_SH, 32'h10, 32'h0000BEEF, 3, 3);
        issue(OP_LW, 32'h6, 32'h13572468, 0, 0);
        issue(6'b000000, 32'h40, 32'h2468ACE0, 0, 0);
        issue(OP_SH, 32'h21, 32'h0000CAFE, 0, 0);

        ack_never = 1'b1;
        issue(OP_SW, 32'h44, 32'h5A5A5A5A, 0, 0);
        issue(OP_LW, 32'h48, 32'hA5A5A5A5, 0, 0);
        ack_never = 1'b0;

        reset_during_read();
        issue(OP_LW, 32'h88, 32'h0F0F0F0F, 1, 0);

        for (int t = 0; t < 300; t++) begin
            op = ops[$urandom_range(0, 6)];
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: a[0] = 1'b0;
                default: a[1:0] = 2'b00;
            endcase
            issue(op, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
